// File: rtl/operand_stage_pkg.sv
// Shared widths and ALU op-code constants used by decode, operand fetch and the ALU.
package operand_stage_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_NOR    = 4'b0101;
  localparam logic [3:0] ALU_SLT    = 4'b0110;
  localparam logic [3:0] ALU_SLTU   = 4'b0111;
  localparam logic [3:0] ALU_SLL    = 4'b1000;
  localparam logic [3:0] ALU_SRL    = 4'b1001;
  localparam logic [3:0] ALU_SRA    = 4'b1010;
  localparam logic [3:0] ALU_LUI    = 4'b1011;
  localparam logic [3:0] ALU_MUL    = 4'b1100;
  localparam logic [3:0] ALU_PASS_A = 4'b1101;
  localparam logic [3:0] ALU_PASS_B = 4'b1110;

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational read ports with write-through bypass,
// one synchronous write port, register 0 hardwired to zero.
module reg_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [ADDR_W-1:0] rd_addr  [2];
  logic [DATA_W-1:0] rd_data  [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;
  assign rd_data_a  = rd_data[0];
  assign rd_data_b  = rd_data[1];

  // Reset outranks the write port; entry 0 is never written so it stays zero.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 :
                           (wr_en && (wr_addr == rd_addr[gi])) ? wr_data :
                           regs_reg[rd_addr[gi]];
    end
  endgenerate

endmodule

// File: rtl/operand_stage.sv
// Operand fetch stage: reads Rs/Rt (or immediate) and presents registered
// operands to the ALU behind a valid/ready handshake with flush.
module operand_stage #(
  parameter int DATA_W     = operand_stage_pkg::DATA_W,
  parameter int REG_ADDR_W = operand_stage_pkg::REG_ADDR_W
) (
  input  logic                  In_CLK,
  input  logic                  In_Reset,
  input  logic                  In_Valid,
  output logic                  Out_Ready,
  input  logic [REG_ADDR_W-1:0] In_RsAddr,
  input  logic [REG_ADDR_W-1:0] In_RtAddr,
  input  logic [DATA_W-1:0]     In_Imm,
  input  logic                  In_UseImm,
  input  logic [3:0]            In_ALUCtrl,
  input  logic                  In_WrEn,
  input  logic [REG_ADDR_W-1:0] In_WrAddr,
  input  logic [DATA_W-1:0]     In_WrData,
  input  logic                  In_Flush,
  output logic                  Out_Valid,
  input  logic                  In_Ready,
  output logic [DATA_W-1:0]     Out_A,
  output logic [DATA_W-1:0]     Out_B,
  output logic [3:0]            Out_ALUCtrl
);

  import operand_stage_pkg::*;

  logic              valid_reg, valid_next;
  logic [DATA_W-1:0] a_reg, a_next;
  logic [DATA_W-1:0] b_reg, b_next;
  logic [3:0]        ctrl_reg, ctrl_next;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic              capture;

  reg_file #(
    .DATA_W (DATA_W),
    .ADDR_W (REG_ADDR_W)
  ) u_reg_file (
    .clk       (In_CLK),
    .srst      (In_Reset),
    .wr_en     (In_WrEn),
    .wr_addr   (In_WrAddr),
    .wr_data   (In_WrData),
    .rd_addr_a (In_RsAddr),
    .rd_data_a (rs_data),
    .rd_addr_b (In_RtAddr),
    .rd_data_b (rt_data)
  );

  assign Out_Ready = (!valid_reg || In_Ready) && !In_Flush;
  assign capture   = In_Valid && Out_Ready;

  // Flush forces Out_Ready low, so it both blocks capture and retires the held op.
  always_comb begin
    valid_next = valid_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    ctrl_next  = ctrl_reg;
    if (capture) begin
      valid_next = 1'b1;
      a_next     = rs_data;
      b_next     = In_UseImm ? In_Imm : rt_data;
      ctrl_next  = In_ALUCtrl;
    end else if (In_Ready || In_Flush) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge In_CLK) begin
    if (In_Reset) begin
      valid_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      ctrl_reg  <= ALU_ADD;
    end else begin
      valid_reg <= valid_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      ctrl_reg  <= ctrl_next;
    end
  end

  assign Out_Valid   = valid_reg;
  assign Out_A       = a_reg;
  assign Out_B       = b_reg;
  assign Out_ALUCtrl = ctrl_reg;

endmodule

// File: tb/tb_operand_stage.sv
// Directed plus randomized bench for operand_stage with an expected-result queue.
module tb_operand_stage;

  logic        In_CLK = 1'b0;
  logic        In_Reset, In_Valid, In_UseImm, In_WrEn, In_Flush, In_Ready;
  logic [3:0]  In_RsAddr, In_RtAddr, In_WrAddr, In_ALUCtrl;
  logic [15:0] In_Imm, In_WrData;
  logic        Out_Ready, Out_Valid;
  logic [15:0] Out_A, Out_B;
  logic [3:0]  Out_ALUCtrl;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  ctrl;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mem [16];
  int          checks = 0;
  int          errors = 0;

  always #5 In_CLK = ~In_CLK;

  operand_stage #(.DATA_W(16), .REG_ADDR_W(4)) dut (
    .In_CLK(In_CLK), .In_Reset(In_Reset), .In_Valid(In_Valid), .Out_Ready(Out_Ready),
    .In_RsAddr(In_RsAddr), .In_RtAddr(In_RtAddr), .In_Imm(In_Imm), .In_UseImm(In_UseImm),
    .In_ALUCtrl(In_ALUCtrl), .In_WrEn(In_WrEn), .In_WrAddr(In_WrAddr), .In_WrData(In_WrData),
    .In_Flush(In_Flush), .Out_Valid(Out_Valid), .In_Ready(In_Ready), .Out_A(Out_A),
    .Out_B(Out_B), .Out_ALUCtrl(Out_ALUCtrl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [3:0] addr);
    if (addr == 4'd0) return 16'h0000;
    if (In_WrEn && In_WrAddr == addr) return In_WrData;
    return mem[addr];
  endfunction

  // One clock: check ready before the edge, update the model, check outputs after.
  task automatic tick(input string tag);
    logic exp_ready;
    exp_t e;
    #1;
    exp_ready = (sb_q.size() == 0 || In_Ready) && !In_Flush;
    chk({tag, ".ready"}, {31'd0, Out_Ready}, {31'd0, exp_ready});
    e.a    = model_rd(In_RsAddr);
    e.b    = In_UseImm ? In_Imm : model_rd(In_RtAddr);
    e.ctrl = In_ALUCtrl;
    @(posedge In_CLK);
    if (In_Reset) begin
      sb_q.delete();
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    end else begin
      if (sb_q.size() != 0 && (In_Ready || In_Flush)) void'(sb_q.pop_front());
      if (In_Valid && exp_ready) sb_q.push_back(e);
      if (In_WrEn && In_WrAddr != 4'd0) mem[In_WrAddr] = In_WrData;
    end
    #1;
    $display("tick %-10s valid=%0b A=%h B=%h ctrl=%h ready=%0b", tag, Out_Valid, Out_A, Out_B,
             Out_ALUCtrl, Out_Ready);
    chk({tag, ".valid"}, {31'd0, Out_Valid}, {31'd0, sb_q.size() != 0});
    if (sb_q.size() != 0) begin
      chk({tag, ".A"}, {16'd0, Out_A}, {16'd0, sb_q[0].a});
      chk({tag, ".B"}, {16'd0, Out_B}, {16'd0, sb_q[0].b});
      chk({tag, ".ctrl"}, {28'd0, Out_ALUCtrl}, {28'd0, sb_q[0].ctrl});
    end
  endtask

  task automatic idle();
    In_Reset = 0; In_Valid = 0; In_UseImm = 0; In_WrEn = 0; In_Flush = 0; In_Ready = 1;
    In_RsAddr = 0; In_RtAddr = 0; In_WrAddr = 0; In_ALUCtrl = 0; In_Imm = 0; In_WrData = 0;
  endtask

  task automatic issue(input logic [3:0] rs, input logic [3:0] rt, input logic use_imm,
                       input logic [15:0] imm, input logic [3:0] ctrl);
    In_Valid = 1; In_RsAddr = rs; In_RtAddr = rt; In_UseImm = use_imm; In_Imm = imm;
    In_ALUCtrl = ctrl;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [15:0] data);
    In_WrEn = 1; In_WrAddr = addr; In_WrData = data;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    idle();
    In_Reset = 1;
    tick("reset0");
    tick("reset1");
    chk("rst.valid", {31'd0, Out_Valid}, 32'd0);
    chk("rst.A", {16'd0, Out_A}, 32'd0);
    chk("rst.B", {16'd0, Out_B}, 32'd0);
    chk("rst.ctrl", {28'd0, Out_ALUCtrl}, 32'd0);

    // Plain register operands
    idle(); wr(4'd3, 16'h1234); tick("wr_r3");
    idle(); wr(4'd5, 16'h00FF); tick("wr_r5");
    idle(); issue(4'd3, 4'd5, 1'b0, 16'h0000, 4'b0001); tick("rs3_rt5");
    chk("rs3_rt5.A_lit", {16'd0, Out_A}, 32'h1234);
    chk("rs3_rt5.B_lit", {16'd0, Out_B}, 32'h00FF);

    // Write-through bypass with immediate operand
    idle(); wr(4'd7, 16'hBEEF); issue(4'd7, 4'd5, 1'b1, 16'hFFFE, 4'b1110); tick("bypass");
    chk("bypass.A_lit", {16'd0, Out_A}, 32'hBEEF);
    chk("bypass.B_lit", {16'd0, Out_B}, 32'hFFFE);

    // Stall three cycles while overwriting the held op's source register
    for (int i = 0; i < 3; i++) begin
      idle(); In_Ready = 0; wr(4'd7, 16'h0000); issue(4'd3, 4'd5, 1'b0, 16'h0, 4'b0010);
      tick("stall");
      chk("stall.A_lit", {16'd0, Out_A}, 32'hBEEF);
    end
    idle(); issue(4'd7, 4'd3, 1'b0, 16'h0, 4'b0011); tick("release");

    // Register zero reads zero even while being written
    idle(); wr(4'd0, 16'hAAAA); issue(4'd0, 4'd0, 1'b0, 16'h0, 4'b0100); tick("r0");
    chk("r0.A_lit", {16'd0, Out_A}, 32'h0000);

    // Flush drops held and incoming op; its write still lands
    idle(); In_Flush = 1; wr(4'd9, 16'h5A5A); issue(4'd5, 4'd3, 1'b0, 16'h0, 4'b0101);
    tick("flush");
    idle(); tick("post_flush");
    idle(); issue(4'd9, 4'd9, 1'b0, 16'h0, 4'b0110); tick("rd_r9");
    chk("rd_r9.A_lit", {16'd0, Out_A}, 32'h5A5A);

    // Reset during a stall
    idle(); In_Ready = 0; issue(4'd3, 4'd5, 1'b0, 16'h0, 4'b0111); tick("stall2");
    idle(); In_Ready = 0; In_Reset = 1; wr(4'd4, 16'h7777); tick("rst_stall");
    idle(); issue(4'd3, 4'd5, 1'b0, 16'h0, 4'b1000); tick("rd_r3_r5");
    idle(); issue(4'd9, 4'd7, 1'b0, 16'h0, 4'b1001); tick("rd_r9_r7");
    idle(); issue(4'd4, 4'd1, 1'b0, 16'h0, 4'b1010); tick("rd_r4_r1");

    // Randomized traffic, including back-to-back captures
    for (int n = 0; n < 60; n++) begin
      idle();
      In_Ready = ($urandom_range(0, 3) != 0);
      In_Flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) != 0)
        issue(4'($urandom), 4'($urandom), 1'($urandom), 16'($urandom), 4'($urandom));
      if ($urandom_range(0, 1) != 0) wr(4'($urandom), 16'($urandom));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
